// File: rtl/trace_pkg.sv
// Shared types and helpers for the trace capture engine: capture FSM states,
// trigger-edge encoding and a saturating accumulator step.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        EDGE_RISING  = 1'b0,
        EDGE_FALLING = 1'b1
    } trig_edge_t;

    // Widest accumulator the helper supports; callers zero-extend into it.
    localparam int SAT_W = 16;

    // One attack (up=1) or decay (up=0) step, clamped to [0, 2**int_w-1].
    // Worked one bit wider than the operands so the add can never wrap.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] acc,
        input logic [SAT_W-1:0] step,
        input logic             up,
        input int               int_w
    );
        logic [SAT_W:0] wide;
        logic [SAT_W:0] limit;
        limit = ((SAT_W+1)'(1) << int_w) - (SAT_W+1)'(1);
        if (up) begin
            wide = {1'b0, acc} + {1'b0, step};
            if (wide > limit) begin
                wide = limit;
            end
        end else begin
            wide = {1'b0, acc} - {1'b0, step};
            if (step > acc) begin
                wide = '0;
            end
        end
        return wide[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: one write port, one registered read port.
// A same-address read and write in one cycle returns the previous contents.
module trace_ram #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [NUM_CH-1:0] rd_data
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [NUM_CH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trace_capture_engine.sv
// Logic-analyser core: synchronises probes, captures a triggered trace into
// RAM and replays it through per-channel attack/decay intensity integrators.
module trace_capture_engine
    import trace_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 16,
    parameter int INT_W  = 5,
    parameter int ATTACK = 1,
    parameter int DECAY  = 1,
    localparam int TRIG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       probe,
    input  logic                    arm,
    input  logic [TRIG_W-1:0]       trig_ch,
    input  logic                    trig_edge,
    input  logic [15:0]             sample_div,
    output logic                    capture_busy,
    output logic                    capture_done,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [NUM_CH-1:0]       ch_mask,
    output logic [NUM_CH*INT_W-1:0] intensity,
    output logic                    intensity_valid
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [NUM_CH-1:0] sync1_reg;
    logic [NUM_CH-1:0] sync_reg;
    logic [NUM_CH-1:0] prev_reg;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [15:0]       div_cnt_reg, div_cnt_next;

    logic              sel_sync, sel_prev, trig_hit, sample_tick;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    logic              rd_en_d1_reg;
    logic              valid_reg;
    logic [NUM_CH-1:0] rd_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync_reg  <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= probe;
            sync_reg  <= sync1_reg;
            prev_reg  <= sync_reg;
        end
    end

    // Channel selects beyond NUM_CH mean free-run: trigger on the first ARMED cycle.
    always_comb begin
        sel_sync = 1'b0;
        sel_prev = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (trig_ch == TRIG_W'(i)) begin
                sel_sync = sync_reg[i];
                sel_prev = prev_reg[i];
            end
        end
        if (int'(trig_ch) >= NUM_CH) begin
            trig_hit = 1'b1;
        end else if (trig_edge == EDGE_FALLING) begin
            trig_hit = sel_prev & ~sel_sync;
        end else begin
            trig_hit = ~sel_prev & sel_sync;
        end
    end

    assign sample_tick = (div_cnt_reg == sample_div);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            div_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            div_cnt_reg <= div_cnt_next;
        end
    end

    // arm always wins: it aborts any capture in progress and re-arms.
    always_comb begin
        state_next   = state_reg;
        wr_ptr_next  = wr_ptr_reg;
        div_cnt_next = div_cnt_reg;
        if (arm) begin
            state_next   = ARMED;
            wr_ptr_next  = '0;
            div_cnt_next = '0;
        end else begin
            case (state_reg)
                ARMED: begin
                    if (trig_hit) begin
                        state_next   = CAPTURE;
                        wr_ptr_next  = ADDR_W'(1);
                        div_cnt_next = '0;
                    end
                end
                CAPTURE: begin
                    if (sample_tick) begin
                        wr_ptr_next  = wr_ptr_reg + ADDR_W'(1);
                        div_cnt_next = '0;
                        if (wr_ptr_reg == LAST_ADDR) begin
                            state_next = DONE;
                        end
                    end else begin
                        div_cnt_next = div_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    always_comb begin
        capture_busy = (state_reg == ARMED) || (state_reg == CAPTURE);
        capture_done = (state_reg == DONE);
        wr_en        = 1'b0;
        wr_addr      = wr_ptr_reg;
        if (!arm) begin
            if (state_reg == ARMED && trig_hit) begin
                wr_en   = 1'b1;
                wr_addr = '0;
            end else if (state_reg == CAPTURE && sample_tick) begin
                wr_en   = 1'b1;
            end
        end
    end

    trace_ram #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (sync_reg),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_en_d1_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            rd_en_d1_reg <= rd_en;
            valid_reg    <= rd_en_d1_reg;
        end
    end

    assign intensity_valid = valid_reg;

    // ch_mask qualifies the RAM bit in the cycle that bit leaves the RAM.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_int
            logic [INT_W-1:0] acc_reg, acc_next;

            always_comb begin
                if (rd_data[gi] & ch_mask[gi]) begin
                    acc_next = INT_W'(sat_step(SAT_W'(acc_reg), SAT_W'(ATTACK), 1'b1, INT_W));
                end else begin
                    acc_next = INT_W'(sat_step(SAT_W'(acc_reg), SAT_W'(DECAY), 1'b0, INT_W));
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    acc_reg <= '0;
                end else if (rd_en_d1_reg) begin
                    acc_reg <= acc_next;
                end
            end

            assign intensity[gi*INT_W +: INT_W] = acc_reg;
        end
    endgenerate

endmodule
